// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth step decode for booth_mult_seq
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Codes match the {Q[0],Qm1} pair; 2'b11 collapses to NOP in booth_decode.
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
    return (q0 ^ qm1) ? {q0, qm1} : BOOTH_NOP;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// rtl/booth_addsub.sv - combinational add/subtract/pass for one Booth step
module booth_addsub
  import booth_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    case (op_i)
      BOOTH_ADD: y_o = a_i + b_i;
      BOOTH_SUB: y_o = a_i - b_i;
      default:   y_o = a_i;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with start/busy/done
// Defining BOOTH_UNSIGNED_EN adds the is_signed port and unsigned operation.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_q,
  input  logic [WIDTH-1:0]   data_m,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int AW = WIDTH + 1;
`ifdef BOOTH_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 2);

  state_e        state_q, state_d;
  logic [AW-1:0] a_q, m_q, a_sum, a_sh, m_ld;
  logic [QW-1:0] q_q, q_sh, q_ld;
  logic          qm1_q, qm1_sh;
  logic [CW-1:0] cnt_q, n_ld;
  logic [PW-1:0] product_q, product_d;
  logic [1:0]    op;
  logic          load, step, last;
`ifdef BOOTH_UNSIGNED_EN
  logic          sgn_q;
`endif

  assign op   = booth_decode(q_q[0], qm1_q);
  assign last = (cnt_q == CW'(1));

  booth_addsub #(.W(AW)) u_addsub (
    .a_i  (a_q),
    .b_i  (m_q),
    .op_i (op),
    .y_o  (a_sum)
  );

  // Arithmetic right shift of {A',Q,Qm1}: the sign of A' is replicated.
  assign {a_sh, q_sh, qm1_sh} = {a_sum[AW-1], a_sum, q_q};

`ifdef BOOTH_UNSIGNED_EN
  assign m_ld = {is_signed & data_m[WIDTH-1], data_m};
  assign q_ld = {is_signed & data_q[WIDTH-1], data_q};
  assign n_ld = is_signed ? CW'(WIDTH) : CW'(WIDTH + 1);
  // Signed runs stop one shift short, so the low product bits sit one place up in Q.
  assign product_d = sgn_q ? PW'({a_sh, q_sh[QW-1:1]}) : PW'({a_sh, q_sh});
`else
  assign m_ld = {data_m[WIDTH-1], data_m};
  assign q_ld = data_q;
  assign n_ld = CW'(WIDTH);
  assign product_d = PW'({a_sh, q_sh});
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        load    = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef BOOTH_UNSIGNED_EN
      sgn_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= '0;
        m_q   <= m_ld;
        q_q   <= q_ld;
        qm1_q <= 1'b0;
        cnt_q <= n_ld;
`ifdef BOOTH_UNSIGNED_EN
        sgn_q <= is_signed;
`endif
      end else if (step) begin
        a_q   <= a_sh;
        q_q   <= q_sh;
        qm1_q <= qm1_sh;
        cnt_q <= cnt_q - CW'(1);
        if (last) product_q <= product_d;
      end
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq (WIDTH=8)
// Covers the BOOTH_UNSIGNED_EN build when that macro is defined.
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   dq = '0;
  logic [W-1:0]   dm = '0;
  logic           sgn_tb = 1'b1;
  logic           busy, done;
  logic [2*W-1:0] product;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int t_acc   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_q    (dq),
    .data_m    (dm),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed (sgn_tb),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]   q;
    logic [W-1:0]   m;
    logic           sgn;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [2*W-1:0] model(input logic [W-1:0] q, input logic [W-1:0] m,
                                           input logic sgn);
    longint a, b;
    if (sgn) begin
      a = longint'($signed(q));
      b = longint'($signed(m));
    end else begin
      a = longint'(q);
      b = longint'(m);
    end
    return (2*W)'(a * b);
  endfunction

  function automatic int model_lat(input logic sgn);
    return sgn ? W : W + 1;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] q, input logic [W-1:0] m, input logic sgn);
    @(negedge clk);
    rst_n  = 1'b1;
    start  = 1'b1;
    dq     = q;
    dm     = m;
    sgn_tb = sgn;
    @(posedge clk);
    #1;
    t_acc  = cyc;
    start  = 1'b0;
    dq     = W'($urandom);
    dm     = W'($urandom);
    sgn_tb = 1'($urandom);
  endtask

  task automatic wait_done(output logic [2*W-1:0] p, output int lat, output int bc);
    bc  = 0;
    lat = -1;
    p   = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = cyc - t_acc;
        p   = product;
        break;
      end
    end
  endtask

  initial begin
    logic [2*W-1:0] p, p1, p2, e;
    int lat, bc, cnt, t1, t2;
    logic [W-1:0] rq, rm;
    logic rs;

    vecs.push_back('{8'd3,   8'd5,   1'b1, 16'h000F});
    vecs.push_back('{8'h80,  8'h80,  1'b1, 16'h4000});
    vecs.push_back('{8'd127, 8'hFF,  1'b1, 16'hFF81});
    vecs.push_back('{8'h80,  8'd127, 1'b1, 16'hC080});
    vecs.push_back('{8'd0,   8'd0,   1'b1, 16'h0000});
    vecs.push_back('{8'hFF,  8'hFF,  1'b1, 16'h0001});
    vecs.push_back('{8'd1,   8'hFF,  1'b1, 16'hFFFF});
    vecs.push_back('{8'd6,   8'd7,   1'b1, 16'd42});
`ifdef BOOTH_UNSIGNED_EN
    vecs.push_back('{8'hFF,  8'hFF,  1'b0, 16'hFE01});
    vecs.push_back('{8'h80,  8'h80,  1'b0, 16'h4000});
    vecs.push_back('{8'hFF,  8'd1,   1'b0, 16'h00FF});
`endif

    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);

    foreach (vecs[i]) begin
      launch(vecs[i].q, vecs[i].m, vecs[i].sgn);
      wait_done(p, lat, bc);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, model_lat(vecs[i].sgn));
      check($sformatf("vec%0d_busy_cycles", i), bc, model_lat(vecs[i].sgn));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_product_hold", i), product, vecs[i].exp);
    end

    // start pulsed mid-RUN must be dropped
    launch(8'd3, 8'd5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    dq    = 8'd100;
    dm    = 8'd100;
    @(negedge clk);
    start = 1'b0;
    wait_done(p, lat, bc);
    check("ignored_start_product", p, 16'h000F);
    check("ignored_start_latency", lat, W);
    cnt = 0;
    bc  = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) cnt++;
      if (busy) bc++;
    end
    check("ignored_start_extra_done", cnt, 0);
    check("ignored_start_extra_busy", bc, 0);
    check("ignored_start_hold", product, 16'h000F);

    // asynchronous reset in the middle of a run
    launch(8'd100, 8'd100, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_product", product, 0);
    repeat (2) @(negedge clk);
    launch(8'd6, 8'd7, 1'b1);
    wait_done(p, lat, bc);
    check("after_reset_product", p, 16'd42);
    check("after_reset_latency", lat, W);

    // back-to-back: start held through DONE
    @(negedge clk);
    start  = 1'b1;
    dq     = 8'd3;
    dm     = 8'd5;
    sgn_tb = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    dq    = 8'hF9;
    dm    = 8'd9;
    t1 = -1;
    t2 = -1;
    p1 = '0;
    p2 = '0;
    for (int k = 0; k < 40 && t2 < 0; k++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          p1 = product;
          @(posedge clk);
          #1;
          start = 1'b0;
        end else begin
          t2 = cyc;
          p2 = product;
        end
      end
    end
    check("b2b_first_latency", t1 - t_acc, W);
    check("b2b_first_product", p1, 16'h000F);
    check("b2b_done_spacing", t2 - t1, W + 1);
    check("b2b_second_product", p2, 16'hFFC1);

    // randomized operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      rq = W'($urandom);
      rm = W'($urandom);
`ifdef BOOTH_UNSIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b1;
`endif
      e = model(rq, rm, rs);
      launch(rq, rm, rs);
      wait_done(p, lat, bc);
      check($sformatf("rand%0d_product_%0h_x_%0h_s%0d", i, rq, rm, rs), p, e);
      check($sformatf("rand%0d_latency", i), lat, model_lat(rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
